time_set_ctrl: RTL and testbench

- Front-panel time-setting controller; the writer/reader on the far side of the seconds/minutes/hours counters' load/data/enable/databus interface.
- Walks the user through seconds, minutes, then hours.
- For each field it reads the live value through the counter's enable/databus path. The user edits it with inc/dec pulses, then it writes the value back with a one-cycle load strobe on a shared 6-bit data bus.
- Sits between the button debouncers and the counter chain. Its editing output freezes the tick chain while a set is in progress.

---
 rtl/time_set_ctrl_if.sv | 21 ++
 rtl/time_set_ctrl.sv | 142 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Load/readback bus between the time-set controller and the sec/min/hr counters.
interface time_set_ctrl_if;
  logic [5:0] databus;
  logic [5:0] data;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       sec_ld;
  logic       min_ld;
  logic       hr_ld;

  modport master (
    input  databus,
    output data, sec_en, min_en, hr_en, sec_ld, min_ld, hr_ld
  );

  modport slave (
    output databus,
    input  data, sec_en, min_en, hr_en, sec_ld, min_ld, hr_ld
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Front-panel time-set controller: fetch, edit and write back sec, min, hr in turn.
// Optional display blink divider enabled by defining TIME_SET_BLINK_EN.
module time_set_ctrl #(
  parameter int SEC_MAX   = 59,
  parameter int MIN_MAX   = 59,
  parameter int HR_MAX    = 23,
  parameter int BLINK_DIV = 25000000
) (
  input  logic           clk,
  input  logic           clear_n,
  input  logic           set_btn,
  input  logic           inc_btn,
  input  logic           dec_btn,
  input  logic           abort_btn,
  time_set_ctrl_if.master bus,
  output logic [5:0]     edit_val,
  output logic [1:0]     field,
  output logic           editing,
  output logic           blink
);

  typedef enum logic [1:0] {IDLE, FETCH, EDIT, COMMIT} state_t;

  state_t     state;
  logic [2:0] en_vec;   // bit 0 = sec, 1 = min, 2 = hr
  logic [2:0] ld_vec;
  logic [5:0] data_reg;
  logic [5:0] cur_max;
  logic       inc_only;
  logic       dec_only;

  assign bus.sec_en = en_vec[0];
  assign bus.min_en = en_vec[1];
  assign bus.hr_en  = en_vec[2];
  assign bus.sec_ld = ld_vec[0];
  assign bus.min_ld = ld_vec[1];
  assign bus.hr_ld  = ld_vec[2];
  assign bus.data   = data_reg;

  assign inc_only = inc_btn & ~dec_btn;
  assign dec_only = dec_btn & ~inc_btn;

  always_comb begin
    case (field)
      2'd0:    cur_max = 6'(SEC_MAX);
      2'd1:    cur_max = 6'(MIN_MAX);
      default: cur_max = 6'(HR_MAX);
    endcase
  end

  function automatic logic [2:0] field_sel(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      field    <= 2'd0;
      edit_val <= 6'd0;
      data_reg <= 6'd0;
      en_vec   <= 3'b000;
      ld_vec   <= 3'b000;
      editing  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (set_btn) begin
            state   <= FETCH;
            field   <= 2'd0;
            en_vec  <= 3'b001;
            editing <= 1'b1;
          end
        end
        FETCH: begin
          // Out-of-range readback (e.g. uninitialised counter) starts editing at 0.
          edit_val <= (bus.databus > cur_max) ? 6'd0 : bus.databus;
          en_vec   <= 3'b000;
          state    <= EDIT;
        end
        EDIT: begin
          if (abort_btn) begin
            state   <= IDLE;
            editing <= 1'b0;
          end else if (set_btn) begin
            state    <= COMMIT;
            data_reg <= edit_val;
            ld_vec   <= field_sel(field);
          end else if (inc_only) begin
            edit_val <= (edit_val == cur_max) ? 6'd0 : edit_val + 6'd1;
          end else if (dec_only) begin
            edit_val <= (edit_val == 6'd0) ? cur_max : edit_val - 6'd1;
          end
        end
        COMMIT: begin
          ld_vec   <= 3'b000;
          data_reg <= 6'd0;
          if (field == 2'd2) begin
            state   <= IDLE;
            field   <= 2'd0;
            editing <= 1'b0;
          end else begin
            state  <= FETCH;
            field  <= field + 2'd1;
            en_vec <= (field == 2'd0) ? 3'b010 : 3'b100;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIME_SET_BLINK_EN
  localparam logic [24:0] DIV_LAST = 25'(BLINK_DIV - 1);

  logic [24:0] div_cnt;

  // Any button activity, or not being in EDIT, restarts the phase with the digit lit.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      div_cnt <= 25'd0;
      blink   <= 1'b1;
    end else if (state == EDIT && !abort_btn && !set_btn && !inc_btn && !dec_btn) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= 25'd0;
        blink   <= ~blink;
      end else begin
        div_cnt <= div_cnt + 25'd1;
      end
    end else begin
      div_cnt <= 25'd0;
      blink   <= 1'b1;
    end
  end
`else
  assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised self-checking bench for time_set_ctrl with a behavioural controller model.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       set_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic       abort_btn = 1'b0;
  logic [5:0] edit_val;
  logic [1:0] field;
  logic       editing;
  logic       blink;

  logic       ovr = 1'b0;     // force databus to 63
  logic       rnd_en = 1'b0;  // let the counters change value while not editing
  logic       chk_on = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  time_set_ctrl_if bus_if ();

  time_set_ctrl #(.BLINK_DIV(4)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .set_btn   (set_btn),
    .inc_btn   (inc_btn),
    .dec_btn   (dec_btn),
    .abort_btn (abort_btn),
    .bus       (bus_if.master),
    .edit_val  (edit_val),
    .field     (field),
    .editing   (editing),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // Counter chain model: sec/min/hr registers with readback and load.
  logic [5:0] cnt [3];
  int         ld_count;

  assign bus_if.databus = ovr ? 6'd63 :
                          (({6{bus_if.sec_en}} & cnt[0]) |
                           ({6{bus_if.min_en}} & cnt[1]) |
                           ({6{bus_if.hr_en}}  & cnt[2]));

  always @(posedge clk or negedge clear_n) begin : counters
    int k;
    if (!clear_n) begin
      cnt[0]   <= 6'd42;
      cnt[1]   <= 6'd7;
      cnt[2]   <= 6'd13;
      ld_count <= 0;
    end else begin
      if (bus_if.sec_ld) cnt[0] <= bus_if.data;
      if (bus_if.min_ld) cnt[1] <= bus_if.data;
      if (bus_if.hr_ld)  cnt[2] <= bus_if.data;
      if (bus_if.sec_ld || bus_if.min_ld || bus_if.hr_ld)
        ld_count <= ld_count + 1;
      else if (rnd_en && !editing && $urandom_range(3) == 0) begin
        k = int'($urandom_range(2));
        cnt[k] <= 6'($urandom_range(63));
      end
    end
  end

  // Behavioural model: phase 0 idle, 1 reading field, 2 adjusting, 3 writing.
  int m_ph, m_f, m_ev, m_since;

  function automatic int fmax(input int ff);
    return (ff == 2) ? 23 : 59;
  endfunction

  always @(posedge clk or negedge clear_n) begin : model
    int v;
    if (!clear_n) begin
      m_ph = 0; m_f = 0; m_ev = 0; m_since = 0;
    end else begin
      case (m_ph)
        0: if (set_btn) begin m_ph = 1; m_f = 0; end
        1: begin
          v = ovr ? 63 : int'(cnt[m_f]);
          m_ev = (v > fmax(m_f)) ? 0 : v;
          m_ph = 2;
          m_since = 0;
        end
        2: begin
          if (abort_btn) m_ph = 0;
          else if (set_btn) m_ph = 3;
          else begin
            if (inc_btn && !dec_btn) m_ev = (m_ev + 1) % (fmax(m_f) + 1);
            if (dec_btn && !inc_btn) m_ev = (m_ev + fmax(m_f)) % (fmax(m_f) + 1);
            if (inc_btn || dec_btn) m_since = 0;
            else m_since = m_since + 1;
          end
        end
        default: begin
          if (m_f == 2) begin m_ph = 0; m_f = 0; end
          else begin m_ph = 1; m_f = m_f + 1; end
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic i, input logic d, input logic a);
    @(posedge clk);
    #2;
    set_btn = s; inc_btn = i; dec_btn = d; abort_btn = a;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_edit_val"}, 32'(edit_val), 0);
    chk({nm, "_field"}, 32'(field), 0);
    chk({nm, "_editing"}, 32'(editing), 0);
    chk({nm, "_blink"}, 32'(blink), 1);
    chk({nm, "_data"}, 32'(bus_if.data), 0);
    chk({nm, "_en_ld"}, 32'({bus_if.sec_en, bus_if.min_en, bus_if.hr_en,
                             bus_if.sec_ld, bus_if.min_ld, bus_if.hr_ld}), 0);
  endtask

  initial begin
    int lc;
    logic [21:0] act_v, exp_v;
    logic [2:0]  e_en, e_ld;
    logic        e_blink;

    fork
      forever begin
        @(negedge clk);
        if (clear_n && chk_on) begin
          e_en = (m_ph == 1) ? (3'b001 << m_f) : 3'b000;
          e_ld = (m_ph == 3) ? (3'b001 << m_f) : 3'b000;
`ifdef TIME_SET_BLINK_EN
          e_blink = (m_ph == 2) ? (((m_since / 4) % 2) == 0) : 1'b1;
`else
          e_blink = 1'b1;
`endif
          exp_v = {e_en, e_ld, (m_ph == 3) ? 6'(m_ev) : 6'd0, 6'(m_ev), 2'(m_f),
                   (m_ph != 0), e_blink};
          act_v = {bus_if.hr_en, bus_if.min_en, bus_if.sec_en,
                   bus_if.hr_ld, bus_if.min_ld, bus_if.sec_ld,
                   bus_if.data, edit_val, field, editing, blink};
          n_chk++;
          if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_model @%0t: got %h expected %h", $time, act_v, exp_v);
          end
        end
      end
    join_none

    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #2 clear_n = 1'b1;
    chk_on = 1'b1;

    // Fetch seconds = 42
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); #1;
    chk("fetch_sec_en", 32'(bus_if.sec_en), 1);
    chk("fetch_field", 32'(field), 0);
    chk("fetch_editing", 32'(editing), 1);
    tick(0, 0, 0, 0); #1;
    chk("edit_val_42", 32'(edit_val), 42);
    chk("edit_sec_en_low", 32'(bus_if.sec_en), 0);

`ifdef TIME_SET_BLINK_EN
    repeat (3) tick(0, 0, 0, 0);
    #1 chk("blink_k3", 32'(blink), 1);
    tick(0, 0, 0, 0); #1 chk("blink_k4", 32'(blink), 0);
    tick(0, 1, 1, 0); tick(0, 0, 0, 0); #1 chk("blink_restart", 32'(blink), 1);
`endif

    repeat (17) tick(0, 1, 0, 0);
    tick(0, 0, 0, 0); #1 chk("inc_to_59", 32'(edit_val), 59);
    tick(0, 1, 0, 0); tick(0, 0, 0, 0); #1 chk("wrap_up_0", 32'(edit_val), 0);
    tick(0, 0, 1, 0); tick(0, 0, 0, 0); #1 chk("wrap_down_59", 32'(edit_val), 59);
    tick(0, 1, 1, 0); tick(0, 0, 0, 0); #1 chk("inc_dec_hold", 32'(edit_val), 59);
    repeat (18) tick(0, 1, 0, 0);
    tick(0, 0, 0, 0); #1 chk("edit_17", 32'(edit_val), 17);

    tick(1, 0, 0, 0); tick(0, 0, 0, 0); #1;
    chk("commit_sec_ld", 32'({bus_if.sec_ld, bus_if.min_ld, bus_if.hr_ld}), 3'b100);
    chk("commit_data_17", 32'(bus_if.data), 17);
    chk("commit_no_en", 32'({bus_if.sec_en, bus_if.min_en, bus_if.hr_en}), 0);
    tick(0, 0, 0, 0); #1;
    chk("fetch_min_en", 32'(bus_if.min_en), 1);
    chk("fetch_min_field", 32'(field), 1);
    tick(0, 0, 0, 0); #1 chk("edit_min_7", 32'(edit_val), 7);
    tick(0, 0, 1, 0); tick(0, 0, 1, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0); #1;
    chk("commit_min_ld", 32'(bus_if.min_ld), 1);
    chk("commit_data_5", 32'(bus_if.data), 5);
    tick(0, 0, 0, 0); #1;
    chk("fetch_hr_en", 32'(bus_if.hr_en), 1);
    chk("fetch_hr_field", 32'(field), 2);
    ovr = 1'b1;
    tick(0, 0, 0, 0); ovr = 1'b0; #1;
    chk("bus63_clamp", 32'(edit_val), 0);
    tick(0, 0, 1, 0); tick(0, 0, 0, 0); #1 chk("hr_wrap_23", 32'(edit_val), 23);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); #1;
    chk("commit_hr_ld", 32'(bus_if.hr_ld), 1);
    chk("commit_data_23", 32'(bus_if.data), 23);
    tick(0, 0, 0, 0); #1;
    chk("idle_editing", 32'(editing), 0);
    chk("idle_data", 32'(bus_if.data), 0);
    chk("idle_field", 32'(field), 0);
    chk("counters_loaded", 32'({cnt[0], cnt[1], cnt[2]}), 32'({6'd17, 6'd5, 6'd23}));

    // Abort beats set and inc in the same cycle
    lc = ld_count;
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
    tick(1, 1, 0, 1); tick(0, 0, 0, 0); #1;
    chk("abort_editing", 32'(editing), 0);
    chk("abort_edit_val", 32'(edit_val), 18);
    repeat (3) tick(0, 0, 0, 0);
    #1 chk("abort_no_load", 32'(ld_count), 32'(lc));

    // Asynchronous clear during EDIT
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
    #1 clear_n = 1'b0;
    #1 chk_reset_outputs("clr_edit");
    @(posedge clk); #2 clear_n = 1'b1;

    // Asynchronous clear while the load strobe is high
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(1, 0, 0, 0);
    tick(0, 0, 0, 0); #1 chk("pre_clr_ld", 32'(bus_if.sec_ld), 1);
    clear_n = 1'b0;
    #1 chk_reset_outputs("clr_commit");
    @(posedge clk); #2 clear_n = 1'b1;

    // Randomised traffic against the model
    rnd_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(7) == 0, $urandom_range(3) == 0,
           $urandom_range(3) == 0, $urandom_range(19) == 0);
      ovr = ($urandom_range(9) == 0);
    end
    tick(0, 0, 0, 0);
    ovr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
